// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, shared-ALU and response signals of the ALU arbiter.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_src;
    logic [15:0] alu_rd;
    logic        alu_z;
    logic        alu_c;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resp_rd;
    logic        resp_z;
    logic        resp_c;
    logic        resp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_rd, alu_z, alu_c, resp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_src,
        output resp_valid, resp_id, resp_rd, resp_z, resp_c, resp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_rd, alu_z, alu_c, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_src,
        input  resp_valid, resp_id, resp_rd, resp_z, resp_c, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter giving two requesters one-at-a-time access
//            to a shared combinational ALU, with registered response.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int         c_SETTLE   = (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0] c_CNT_LOAD = 4'(c_SETTLE - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b000;

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic [2:0]  r_alu_op;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_src;
    logic        r_resp_id;
    logic [15:0] r_resp_rd;
    logic        r_resp_z;
    logic        r_resp_c;
    logic        r_resp_err;

    logic        w_idle;
    logic        w_accept;
    logic        w_gnt_id;
    logic [2:0]  w_sel_op;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;
    logic        w_illegal;

    // Ready is gated by rst_n so nothing is offered while reset is asserted.
    assign w_idle    = (r_state == c_IDLE) && rst_n;
    assign w_gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_accept  = w_idle && (bus.req0_valid || bus.req1_valid);
    assign w_sel_op  = w_gnt_id ? bus.req1_op : bus.req0_op;
    assign w_sel_a   = w_gnt_id ? bus.req1_a  : bus.req0_a;
    assign w_sel_b   = w_gnt_id ? bus.req1_b  : bus.req0_b;
    assign w_illegal = (w_sel_op == 3'b010) || (w_sel_op == 3'b011);

    assign bus.req0_ready = w_accept && !w_gnt_id;
    assign bus.req1_ready = w_accept &&  w_gnt_id;

    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_src    = r_alu_src;

    assign bus.resp_valid = (r_state == c_RESP);
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_z     = r_resp_z;
    assign bus.resp_c     = r_resp_c;
    assign bus.resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_alu_op     <= 3'b000;
            r_alu_a      <= 16'h0000;
            r_alu_src    <= 16'h0000;
            r_resp_id    <= 1'b0;
            r_resp_rd    <= 16'h0000;
            r_resp_z     <= 1'b0;
            r_resp_c     <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_gnt_id;
                        r_resp_id    <= w_gnt_id;
                        // Illegal ops never touch the ALU; the error response is formed here.
                        if (w_illegal) begin
                            r_resp_rd  <= 16'h0000;
                            r_resp_z   <= 1'b0;
                            r_resp_c   <= 1'b0;
                            r_resp_err <= 1'b1;
                            r_state    <= c_RESP;
                        end else begin
                            r_alu_op  <= w_sel_op;
                            r_alu_a   <= w_sel_a;
                            r_alu_src <= w_sel_b;
                            r_cnt     <= c_CNT_LOAD;
                            r_state   <= c_EXEC;
                        end
                    end
                end
                c_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_rd  <= bus.alu_rd;
                        r_resp_z   <= bus.alu_z;
                        r_resp_c   <= (r_alu_op == c_OP_ADD) ? bus.alu_c : 1'b0;
                        r_resp_err <= 1'b0;
                        r_state    <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    logic [16:0] w_alu_t;

    alu_arbiter_if u_if ();

    alu_arbiter #(.SETTLE_CYCLES(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: sub carry is the borrow and shl carry is the shifted-out bit,
    // so a response carry that is not forced to 0 shows up.
    always_comb begin
        w_alu_t = 17'h0;
        case (u_if.alu_op)
            3'b000:  w_alu_t = {1'b0, u_if.alu_a} + {1'b0, u_if.alu_src};
            3'b001:  w_alu_t = {1'b0, u_if.alu_a} - {1'b0, u_if.alu_src};
            3'b100:  w_alu_t = {u_if.alu_a, 1'b0};
            3'b101:  w_alu_t = {1'b0, u_if.alu_a ^ u_if.alu_src};
            3'b110:  w_alu_t = {1'b0, u_if.alu_a | u_if.alu_src};
            3'b111:  w_alu_t = {1'b0, u_if.alu_a & u_if.alu_src};
            default: w_alu_t = 17'h0;
        endcase
    end
    assign u_if.alu_rd = w_alu_t[15:0];
    assign u_if.alu_c  = w_alu_t[16];
    assign u_if.alu_z  = (w_alu_t[15:0] == 16'h0000);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id == 1'b0) begin
            u_if.req0_valid = 1'b1; u_if.req0_op = op; u_if.req0_a = a; u_if.req0_b = b;
        end else begin
            u_if.req1_valid = 1'b1; u_if.req1_op = op; u_if.req1_a = a; u_if.req1_b = b;
        end
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!u_if.resp_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_op(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] exp_rd,
                         input logic exp_z, input logic exp_c, input logic exp_err);
        int cyc;
        set_req(id, op, a, b);
        #1;
        chk_eq("ready0", u_if.req0_ready, !id);
        chk_eq("ready1", u_if.req1_ready, id);
        step();
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        wait_resp(cyc);
        chk_eq("latency", cyc, exp_lat);
        chk_eq("resp_id", u_if.resp_id, id);
        chk_eq("resp_rd", u_if.resp_rd, exp_rd);
        chk_eq("resp_z", u_if.resp_z, exp_z);
        chk_eq("resp_c", u_if.resp_c, exp_c);
        chk_eq("resp_err", u_if.resp_err, exp_err);
        u_if.resp_ready = 1'b1;
        step();
        u_if.resp_ready = 1'b0;
        chk_eq("idle_after_hs", u_if.resp_valid, 1'b0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        u_if.resp_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        int cyc;
        n_total = 0;
        n_bad   = 0;
        u_if.req0_op = 3'b000; u_if.req0_a = 16'h0; u_if.req0_b = 16'h0;
        u_if.req1_op = 3'b000; u_if.req1_a = 16'h0; u_if.req1_b = 16'h0;
        do_reset();

        chk_eq("rst_ready0", u_if.req0_ready, 1'b0);
        chk_eq("rst_ready1", u_if.req1_ready, 1'b0);
        chk_eq("rst_resp_valid", u_if.resp_valid, 1'b0);
        chk_eq("rst_resp_fields", {u_if.resp_id, u_if.resp_rd, u_if.resp_z, u_if.resp_c, u_if.resp_err}, 32'h0);
        chk_eq("rst_alu", {u_if.alu_op, u_if.alu_a, u_if.alu_src}, 32'h0);
        rst_n = 1'b1;

        // Legal ops, one requester at a time
        do_op(1'b0, 3'b000, 16'h0001, 16'h0001, 2, 16'h0002, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 3'b000, 16'hFFFF, 16'h0001, 2, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(1'b0, 3'b001, 16'h0005, 16'h0005, 2, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(1'b1, 3'b001, 16'h0003, 16'h0005, 2, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 3'b100, 16'h8001, 16'h0000, 2, 16'h0002, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 3'b101, 16'hF0F0, 16'h0FF0, 2, 16'hFF00, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 3'b111, 16'hFF00, 16'h0F0F, 2, 16'h0F00, 1'b0, 1'b0, 1'b0);

        // Illegal ops: one-cycle error response, ALU drive untouched
        do_op(1'b0, 3'b011, 16'h1111, 16'h2222, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk_eq("illegal_alu_op", u_if.alu_op, 3'b111);
        chk_eq("illegal_alu_a", u_if.alu_a, 16'hFF00);
        chk_eq("illegal_alu_src", u_if.alu_src, 16'h0F0F);
        do_op(1'b1, 3'b010, 16'h3333, 16'h4444, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 3'b110, 16'h00F0, 16'h000F, 2, 16'h00FF, 1'b0, 1'b0, 1'b0);

        // Contention from reset: strict alternation starting with req0
        do_reset();
        rst_n = 1'b1;
        set_req(1'b0, 3'b000, 16'h0002, 16'h0003);
        set_req(1'b1, 3'b111, 16'h00FF, 16'h0F0F);
        u_if.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            cyc = 0;
            while (!(u_if.req0_ready || u_if.req1_ready) && cyc < 20) begin
                step();
                #1;
                cyc++;
            end
            chk_eq("cont_gnt0", u_if.req0_ready, (k % 2) == 0);
            chk_eq("cont_gnt1", u_if.req1_ready, (k % 2) == 1);
            step();
            wait_resp(cyc);
            chk_eq("cont_latency", cyc, 2);
            chk_eq("cont_no_ready", u_if.req0_ready || u_if.req1_ready, 1'b0);
            chk_eq("cont_resp_id", u_if.resp_id, k % 2);
            chk_eq("cont_resp_rd", u_if.resp_rd, ((k % 2) == 1) ? 16'h000F : 16'h0005);
            step();
        end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        u_if.resp_ready = 1'b0;
        step();

        // Backpressure: response held while req1 waits
        set_req(1'b0, 3'b110, 16'h1200, 16'h0034);
        set_req(1'b1, 3'b101, 16'hAAAA, 16'h5555);
        #1;
        chk_eq("bp_gnt0", u_if.req0_ready, 1'b1);
        step();
        u_if.req0_valid = 1'b0;
        wait_resp(cyc);
        for (int i = 0; i < 5; i++) begin
            chk_eq("bp_valid", u_if.resp_valid, 1'b1);
            chk_eq("bp_rd", u_if.resp_rd, 16'h1234);
            chk_eq("bp_no_ready1", u_if.req1_ready, 1'b0);
            step();
        end
        u_if.resp_ready = 1'b1;
        step();
        u_if.resp_ready = 1'b0;
        #1;
        chk_eq("bp_released", u_if.resp_valid, 1'b0);
        chk_eq("bp_idle_ready1", u_if.req1_ready, 1'b1);
        u_if.req1_valid = 1'b0;
        step();

        // Reset during EXEC abandons the operation
        set_req(1'b0, 3'b000, 16'h0007, 16'h0008);
        #1;
        chk_eq("mid_gnt0", u_if.req0_ready, 1'b1);
        step();
        u_if.req0_valid = 1'b0;
        chk_eq("mid_exec_alu_a", u_if.alu_a, 16'h0007);
        rst_n = 1'b0;
        step();
        chk_eq("mid_rst_valid", u_if.resp_valid, 1'b0);
        chk_eq("mid_rst_alu", {u_if.alu_op, u_if.alu_a, u_if.alu_src}, 32'h0);
        chk_eq("mid_rst_resp", {u_if.resp_id, u_if.resp_rd, u_if.resp_z, u_if.resp_c, u_if.resp_err}, 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk_eq("mid_no_resp", u_if.resp_valid, 1'b0);
        set_req(1'b1, 3'b111, 16'h00FF, 16'h0F0F);
        do_op(1'b0, 3'b000, 16'h0001, 16'h0002, 2, 16'h0003, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
